subf_seq: RTL and testbench
===========================

Name: subf_seq

Overview:
- Multi-cycle integer subtractor for the CPU datapath. Computes a - b as a + ~b + 1, one CHUNK-bit slice per cycle, with the carry held in a register between slices.
- Produces the difference plus borrow, overflow and zero flags for branch compare and SUB instructions.
- Uses valid/ready handshakes on the input and output sides so the control unit can stall on it.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH exactly. N = WIDTH/CHUNK slices.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a and b are valid.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- data_out  out  WIDTH  a - b modulo 2^WIDTH.
- borrow  out  1  unsigned a < b (inverse of the final carry).
- overflow  out  1  signed overflow.
- zero  out  1  data_out == 0.

Behaviour:
- FSM has three states: IDLE, RUN, DONE.
- Reset (async, rst=1):
  - state goes to IDLE; slice counter, carry register, operand registers and data_out go to 0.
  - out_valid=0, borrow=0, overflow=0, zero=0.
  - in_ready=0 while rst is high; in_ready is 1 in IDLE otherwise.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a rising edge: latch a, latch ~b, set carry=1, set counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add slice [counter*CHUNK +: CHUNK] of a, ~b and carry. Write the sum into the same slice of the result register, update carry, increment the counter.
  - When the slice N-1 is written, go to DONE on that same edge.
  - Latency: out_valid rises exactly N cycles after the accepting edge (4 cycles at the defaults).
- DONE:
  - out_valid=1, in_ready=0.
  - data_out and all flags are registered and hold stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0 and go to IDLE. in_ready=1 the following cycle; there is no same-cycle accept.
- Flags, registered on entry to DONE:
  - borrow = ~final carry.
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (data_out[WIDTH-1] != a[WIDTH-1]).
  - zero = (data_out == 0).
- Operand changes on a/b after acceptance are ignored.
- in_valid seen outside IDLE is ignored and not queued.
- data_out may show partial slices during RUN; only the value while out_valid=1 is defined.
- Reset asserted in any state, including mid-RUN: returns to IDLE with reset values; the in-flight result is discarded.
- Wrap-around: a result below 0 wraps modulo 2^WIDTH (for example, 0 - 1 gives all ones with borrow=1).

Optional Feature:
- Macro: SUBF_SEQ_CMP_EN.
- When defined:
  - Extra outputs lt (1 bit) and ltu (1 bit), registered with the other flags.
  - lt = data_out[WIDTH-1] ^ overflow (signed a < b).
  - ltu = borrow.
  - Both reset to 0 and are valid only while out_valid=1.
- When not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. a=5, b=3 -> data_out=2, borrow=0, overflow=0, zero=0; out_valid high exactly 4 cycles after the accept edge.
2. Two back-to-back cases:
   - a=3, b=5 -> data_out=0xFFFFFFFE, borrow=1, overflow=0.
   - a=0x00000100, b=1 -> data_out=0x000000FF (borrow crosses a slice boundary), borrow=0.
3. Signed overflow cases:
   - a=0x80000000, b=1 -> data_out=0x7FFFFFFF, overflow=1, borrow=0.
   - With SUBF_SEQ_CMP_EN defined: lt=1, ltu=0.
4. a=b=0x12345678 -> data_out=0, zero=1, borrow=0. Also pulse in_valid during RUN with other operands -> ignored, result unchanged.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, data_out and flags stable, in_ready=0. Raise out_ready -> out_valid drops next edge, in_ready=1 the cycle after.
6. Assert rst after 2 RUN cycles of a=9, b=4 -> all outputs 0 immediately (async). Release rst, issue a=10, b=7 -> data_out=3 after 4 cycles.

Source files
------------

// File: rtl/subf_seq.sv
// subf_seq: multi-cycle subtractor computing a - b as a + ~b + 1, one CHUNK-bit slice per cycle.
// Optional macro SUBF_SEQ_CMP_EN adds registered lt/ltu compare outputs.
module subf_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             borrow,
  output logic             overflow,
`ifdef SUBF_SEQ_CMP_EN
  output logic             lt,
  output logic             ltu,
`endif
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, nb_q;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] res_nx;
  logic             last, ovf_nx;

  // Slice select and write-back as explicit muxes keep the indexing width-clean.
  always_comb begin
    a_sl   = '0;
    b_sl   = '0;
    res_nx = data_out;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = nb_q[i*CHUNK +: CHUNK];
      end
    end
    sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) res_nx[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end
    last   = (cnt == CW'(N-1));
    // nb_q holds ~b, so its inverted MSB is the sign of b.
    ovf_nx = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (res_nx[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      nb_q     <= '0;
      data_out <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
`ifdef SUBF_SEQ_CMP_EN
      lt       <= 1'b0;
      ltu      <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          nb_q  <= ~b;
          carry <= 1'b1;
          cnt   <= '0;
        end
        RUN: begin
          data_out <= res_nx;
          carry    <= sum[CHUNK];
          cnt      <= cnt + 1'b1;
          if (last) begin
            borrow   <= ~sum[CHUNK];
            overflow <= ovf_nx;
            zero     <= (res_nx == '0);
`ifdef SUBF_SEQ_CMP_EN
            lt       <= res_nx[WIDTH-1] ^ ovf_nx;
            ltu      <= ~sum[CHUNK];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subf_seq.sv
// tb_subf_seq: scoreboard bench for subf_seq; directed plan cases plus randomized traffic
// with random output backpressure, checked against a plain-arithmetic reference model.
module tb_subf_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             in_ready, out_valid, borrow, overflow, zero;
  logic [WIDTH-1:0] data_out;
`ifdef SUBF_SEQ_CMP_EN
  logic             lt, ltu;
`endif

  subf_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .borrow(borrow), .overflow(overflow),
`ifdef SUBF_SEQ_CMP_EN
    .lt(lt), .ltu(ltu),
`endif
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic br, ov, z, lt, ltu;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   rnd_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from a wide signed difference.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t   e;
    longint sd, mx, mn;
    mx   = (64'sd1 <<< (WIDTH-1)) - 1;
    mn   = -(64'sd1 <<< (WIDTH-1));
    sd   = longint'($signed(x)) - longint'($signed(y));
    e.d  = x - y;
    e.br = (x < y);
    e.ov = (sd > mx) || (sd < mn);
    e.z  = (x == y);
    e.lt = ($signed(x) < $signed(y));
    e.ltu = (x < y);
    return e;
  endfunction

  // Monitor: compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out", 64'(data_out), 64'(e.d));
        chk("borrow", 64'(borrow), 64'(e.br));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("zero", 64'(zero), 64'(e.z));
`ifdef SUBF_SEQ_CMP_EN
        chk("lt", 64'(lt), 64'(e.lt));
        chk("ltu", 64'(ltu), 64'(e.ltu));
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; optionally push the expected result.
  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit push);
    int t = 0;
    a = x; b = y; in_valid = 1'b1;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'd1, 64'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back(model(x, y));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return {1'b0, {(WIDTH-1){1'b1}}};
      default: return WIDTH'($urandom());
    endcase
  endfunction

  initial begin
    int lat;
    logic [WIDTH-1:0] hold_d;
    logic [2:0] hold_f;

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_flags", 64'({borrow, overflow, zero}), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();

    // 1: basic with latency
    issue(32'd5, 32'd3, 1);
    wait_out(lat);
    chk("t1_latency", 64'(lat), 64'(N));
    chk("t1_data", 64'(data_out), 64'd2);

    // 2: back-to-back, negative wrap and cross-slice borrow
    issue(32'd3, 32'd5, 1);
    wait_out(lat);
    chk("t2a_data", 64'(data_out), 64'hFFFFFFFE);
    chk("t2a_borrow", 64'(borrow), 64'd1);
    issue(32'h100, 32'd1, 1);
    wait_out(lat);
    chk("t2b_data", 64'(data_out), 64'hFF);

    // 3: signed overflow
    issue(32'h80000000, 32'd1, 1);
    wait_out(lat);
    chk("t3_data", 64'(data_out), 64'h7FFFFFFF);
    chk("t3_overflow", 64'(overflow), 64'd1);
`ifdef SUBF_SEQ_CMP_EN
    chk("t3_lt", 64'(lt), 64'd1);
    chk("t3_ltu", 64'(ltu), 64'd0);
`endif

    // 4: equal operands, in_valid pulsed during RUN must be ignored
    issue(32'h12345678, 32'h12345678, 1);
    a = 32'hDEADBEEF; b = 32'd1; in_valid = 1'b1;
    tick();
    chk("t4_busy_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    chk("t4_latency", 64'(lat), 64'(N-2));
    chk("t4_zero", 64'(zero), 64'd1);
    chk("t4_data", 64'(data_out), 64'd0);

    // 5: backpressure in DONE
    tick();
    out_ready = 1'b0;
    issue(32'h00010000, 32'h00020003, 1);
    wait_out(lat);
    hold_d = data_out;
    hold_f = {borrow, overflow, zero};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_data", 64'(data_out), 64'(hold_d));
      chk("t5_hold_flags", 64'({borrow, overflow, zero}), 64'(hold_f));
      chk("t5_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t5_valid_drop", 64'(out_valid), 64'd0);
    chk("t5_in_ready_back", 64'(in_ready), 64'd1);

    // 6: reset mid-RUN discards the result
    issue(32'd9, 32'd4, 0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_data", 64'(data_out), 64'd0);
    chk("t6_rst_flags", 64'({borrow, overflow, zero}), 64'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_no_stale_valid", 64'(out_valid), 64'd0);
    issue(32'd10, 32'd7, 1);
    wait_out(lat);
    chk("t6_latency", 64'(lat), 64'(N));
    chk("t6_data", 64'(data_out), 64'd3);
    tick();

    // Randomized traffic with random backpressure
    rnd_on = 1;
    for (int k = 0; k < 60; k++) begin
      logic [WIDTH-1:0] x, y;
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? x : pick();
      issue(x, y, 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int t = 0; t < 500 && sb.size() != 0; t++) tick();
    rnd_on = 0;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
